// File: rtl/compuerta_pkg.sv
// Shared types and defaults for the gate-controller lane arbiter.
// Configuration macro used by the arbiter: ARB_TIMEOUT_EN (grant timeout logic).
package compuerta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT  = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_t;

  localparam int unsigned DEF_N_LANES        = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_LANE_W = idx_w(DEF_N_LANES);

endpackage

// File: rtl/arbitro_compuerta_rr_selector.sv
// Combinational round-robin scan: first set req bit starting at ptr, wrapping.
// Offset 0 (the lane at ptr) has the highest priority.
module rr_selector
  import compuerta_pkg::*;
#(
  parameter int unsigned N_LANES = DEF_N_LANES,
  localparam int unsigned LW     = idx_w(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [LW-1:0]      ptr,
  output logic               found,
  output logic [LW-1:0]      idx
);

  logic [LW-1:0]      cand [N_LANES];
  logic [N_LANES-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_scan
      logic [LW:0] sum_w;
      assign sum_w   = {1'b0, ptr} + (LW+1)'(gi);
      assign cand[gi] = (sum_w >= (LW+1)'(N_LANES)) ? LW'(sum_w - (LW+1)'(N_LANES))
                                                    : LW'(sum_w);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/arbitro_compuerta.sv
// Round-robin arbiter sharing one gate controller among N entry lanes.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module arbitro_compuerta
  import compuerta_pkg::*;
#(
  parameter int unsigned N_LANES        = DEF_N_LANES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned LW            = idx_w(N_LANES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_LANES-1:0] req,
  input  logic               done,
  input  logic               alarma_in,
  output logic [N_LANES-1:0] grant,
  output logic [LW-1:0]      lane_id,
  output logic               busy,
  output logic               timeout
);

  generate
    if (N_LANES < 2 || N_LANES > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("arbitro_compuerta: N_LANES must be 2..8 and TIMEOUT_CYCLES >= 2");
    end
  endgenerate

  arb_state_t         state_reg, state_next;
  logic [N_LANES-1:0] grant_reg, grant_next;
  logic [LW-1:0]      lane_reg,  lane_next;
  logic [LW-1:0]      ptr_reg,   ptr_next;
  logic               busy_reg,  busy_next;
  logic               sel_found;
  logic [LW-1:0]      sel_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = idx_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_reg, timer_next;
  logic          timeout_reg, timeout_next;
`endif

  rr_selector #(.N_LANES(N_LANES)) u_sel (
    .req   (req),
    .ptr   (ptr_reg),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      lane_reg  <= '0;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      lane_reg  <= lane_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= busy_next;
`ifdef ARB_TIMEOUT_EN
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    lane_next  = lane_reg;
    ptr_next   = ptr_reg;
    busy_next  = busy_reg;
`ifdef ARB_TIMEOUT_EN
    timer_next   = timer_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        grant_next = '0;
        lane_next  = '0;
        busy_next  = 1'b0;
        if (!alarma_in && sel_found) begin
          state_next = ST_GRANT;
          grant_next = N_LANES'(1) << sel_idx;
          lane_next  = sel_idx;
          busy_next  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          timer_next = '0;
`endif
        end
      end
      ST_GRANT: begin
        // done outranks abandonment, alarm and expiry; the pointer moves past the served lane.
        if (done || !req[lane_reg]) begin
          state_next = ST_IDLE;
          grant_next = '0;
          lane_next  = '0;
          busy_next  = 1'b0;
          ptr_next   = (lane_reg == LW'(N_LANES - 1)) ? '0 : lane_reg + 1'b1;
        end else if (alarma_in) begin
          state_next = ST_LOCKED;
`ifdef ARB_TIMEOUT_EN
        end else if (timer_reg == TMAX) begin
          state_next   = ST_IDLE;
          grant_next   = '0;
          lane_next    = '0;
          busy_next    = 1'b0;
          ptr_next     = (lane_reg == LW'(N_LANES - 1)) ? '0 : lane_reg + 1'b1;
          timeout_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
`endif
        end
      end
      ST_LOCKED: begin
        if (!alarma_in) state_next = ST_GRANT;
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        lane_next  = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign grant   = grant_reg;
  assign lane_id = lane_reg;
  assign busy    = busy_reg;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Directed bench for arbitro_compuerta (2 lanes, TIMEOUT_CYCLES=8).
// Timeout scenarios follow whether ARB_TIMEOUT_EN is defined for the build.
module tb_arbitro_compuerta;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic       done;
  logic       alarma_in;
  logic [1:0] grant;
  logic [0:0] lane_id;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_compuerta #(.N_LANES(2), .TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .alarma_in (alarma_in),
    .grant     (grant),
    .lane_id   (lane_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [1:0] g, input logic l,
                           input logic b, input logic t);
    check({tag, ".grant"},   32'(grant),   32'(g));
    check({tag, ".lane_id"}, 32'(lane_id), 32'(l));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    logic [1:0] exp_g;
    reset = 1'b0; req = 2'b00; done = 1'b0; alarma_in = 1'b0;
    tick(); tick();
    check_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); tick();

    // Single lane: grant one cycle after req, release on done.
    req = 2'b01;
    tick();
    check_out("single_grant", 2'b01, 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("single_hold", 32'(grant), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("single_release", 2'b00, 1'b0, 1'b0, 1'b0);

    // Fairness: ptr is 1 now, so lane 1 goes first, then alternate with an idle gap.
    req = 2'b11;
    exp_g = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("fair%0d_grant", k), 32'(grant), 32'(exp_g));
      check($sformatf("fair%0d_lane", k), 32'(lane_id), (exp_g == 2'b10) ? 32'd1 : 32'd0);
      tick(); tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      if (k == 3) req = 2'b00;
      check($sformatf("fair%0d_gap", k), 32'(grant), 32'h0);
      exp_g = (exp_g == 2'b10) ? 2'b01 : 2'b10;
    end

    // Alarm in IDLE blocks arbitration.
    alarma_in = 1'b1; req = 2'b11;
    tick(); tick();
    check("alarm_idle_grant", 32'(grant), 32'h0);
    check("alarm_idle_busy",  32'(busy),  32'h0);
    alarma_in = 1'b0;
    tick();
    check("post_alarm_grant", 32'(grant), 32'h2);

    // Alarm during GRANT: grant held, done ignored.
    alarma_in = 1'b1;
    tick();
    check("lock_hold", 32'(grant), 32'h2);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("lock_done_ignored", 2'b10, 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick();
    alarma_in = 1'b0;
    tick();
    check("unlock_grant", 32'(grant), 32'h2);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("unlock_release", 2'b00, 1'b0, 1'b0, 1'b0);

    // Timeout behaviour (ptr=0, lane 0 only).
    req = 2'b01;
    tick();
    check("tmo_grant", 32'(grant), 32'h1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) tick();
    check_out("tmo_before", 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("tmo_pulse", 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("tmo_regrant", 2'b01, 1'b0, 1'b1, 1'b0);
    // Timer freezes during LOCKED: 3 counted, lock, then 4 more before expiry edge.
    tick(); tick(); tick();
    alarma_in = 1'b1;
    tick(); tick(); tick();
    alarma_in = 1'b0;
    tick();
    tick(); tick(); tick(); tick();
    check_out("tmo_resume_hold", 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("tmo_resume_pulse", 2'b00, 1'b0, 1'b0, 1'b1);
    // Collision: done on the expiry cycle releases without a pulse.
    tick();
    check("coll_grant", 32'(grant), 32'h1);
    for (int k = 1; k < 8; k++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("coll_release", 2'b00, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    tick();
`else
    for (int k = 0; k < 12; k++) tick();
    check_out("notmo_hold", 2'b01, 1'b0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 2'b00;
    check_out("notmo_release", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
`endif

    // Abandonment: lane 1 granted (ptr=1), then its req drops.
    req = 2'b10;
    tick();
    check("aband_grant", 32'(grant), 32'h2);
    req = 2'b00;
    tick();
    check_out("aband_release", 2'b00, 1'b0, 1'b0, 1'b0);

    // Async reset mid-grant with ptr=1; afterwards arbitration restarts at lane 0.
    req = 2'b11;
    tick();
    check("rst_pre_grant", 32'(grant), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("rst_pre_grant2", 32'(grant), 32'h2);
    #2 reset = 1'b0;
    #1;
    check_out("async_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_out("after_reset", 2'b01, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/arbitro_compuerta.md
Name: arbitro_compuerta

Overview:
- Round-robin arbiter that shares one gate controller (password check, barrier arm, alarm) between N entry lanes.
- Sits between the per-lane vehicle sensors and the controller.
- Grants exactly one lane at a time and releases it on the controller's "vehicle passed" pulse, on lane abandonment, or on timeout.
- Freezes arbitration while the controller is in alarm.

Parameters:
- N_LANES, 2, number of requesting lanes (2..8).
- TIMEOUT_CYCLES, 64, maximum grant duration in clock cycles without done before forced release (>=2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  N_LANES  per-lane vehicle-present request, level.
- done  input  1  one-cycle pulse from the gate controller: vehicle passed, lane finished.
- alarma_in  input  1  gate controller alarm/lock level.
- grant  output  N_LANES  one-hot grant, registered.
- lane_id  output  $clog2(N_LANES)  index of the granted lane; 0 when idle.
- busy  output  1  high while any grant is active or arbitration is locked.
- timeout  output  1  one-cycle pulse on forced release by timeout.

Behaviour:
- Reset (async, reset=0): state IDLE, grant=0, lane_id=0, busy=0, timeout=0, round-robin pointer ptr=0, timer=0.
- States: IDLE, GRANT, LOCKED. All outputs are registered.
- IDLE:
  - If alarma_in=1, stay in IDLE; no grant issued.
  - Else if any req bit is set, select the first set bit scanning ptr, ptr+1, ..., wrapping modulo N_LANES.
  - On the next edge: grant that lane, set lane_id, busy=1, timer=0, go to GRANT.
  - Latency from req to grant is 1 cycle.
- GRANT, checks in priority order:
  1. done=1: grant=0, busy=0, ptr=(lane_id+1) mod N_LANES, go to IDLE.
  2. req[lane_id]=0 (vehicle left): same release as case 1; no timeout pulse.
  3. alarma_in=1: go to LOCKED; grant is held and the timer freezes.
  4. timer=TIMEOUT_CYCLES-1: release as in case 1 and pulse timeout=1 for one cycle.
  5. Otherwise: timer increments.
- LOCKED:
  - grant and busy are held and the timer is frozen.
  - done is ignored.
  - When alarma_in returns to 0, go back to GRANT on the next edge; timer resumes from its frozen value.
- After any release, IDLE lasts at least 1 cycle. The next grant appears no earlier than 2 cycles after done.
- done in IDLE is ignored.
- If done and timeout expiry occur in the same cycle, done wins and no timeout pulse is produced.
- grant is never multi-hot. grant=0 whenever the state is IDLE.
- Requests that drop before being granted are simply not served; no queuing.
- Reset mid-grant clears everything immediately (asynchronous); ptr returns to 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: timer, TIMEOUT_CYCLES check and timeout output are active as specified above.
- Undefined:
  - No timer register is synthesised.
  - GRANT releases only on done or on req drop.
  - timeout is tied to 0.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package (compuerta_pkg):
  - State encodings: IDLE=2'b00, GRANT=2'b01, LOCKED=2'b10.
  - Default N_LANES and TIMEOUT_CYCLES.
  - A width helper constant for lane_id.
- One natural sub-module: rr_selector.
  - Combinational.
  - Inputs: req and ptr.
  - Outputs: a found flag and the selected index using the wrap-around scan.
  - Instantiated once in arbitro_compuerta.

Test Plan:
- Single lane: reset released, req=2'b01 at cycle 5 → grant=2'b01 and lane_id=0 at cycle 6. done pulse at cycle 10 → grant=0 at cycle 11 and ptr=1.
- Fairness: req=2'b11 held constantly, done every 4 cycles → grants alternate 01, 10, 01, 10, with one idle cycle between each.
- Timeout (TIMEOUT_CYCLES=8, ARB_TIMEOUT_EN): req=2'b01, no done → timeout=1 for one cycle exactly 8 cycles after the grant, then grant=0. With the macro undefined, the grant holds indefinitely.
- Alarm: alarma_in=1 during GRANT for 5 cycles, done pulsed inside that window → grant held and done ignored. After alarm clears, the timer resumes and a later done releases. alarma_in=1 in IDLE with req=2'b11 → no grant.
- Abandonment and collision: req[lane_id] drops mid-grant → release next edge, no timeout. done on the same cycle as timer expiry → release with timeout=0.
- Async reset: assert reset=0 mid-GRANT between clock edges → grant, busy and timeout go to 0 immediately. Next arbitration starts from lane 0.
